// File: rtl/qea_host_sequencer.sv
// Host-side sequencer for one QEA run: loads the context RAM from a stream,
// writes the |0...0> initial state, starts QEA and times it, then streams every
// state row back out over a valid/ready/last interface.
module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int READ_LATENCY            = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_run,
    input  logic                                i_abort,
    input  logic [MAX_QBIT_WIDTH-1:0]           i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]    i_ins_num,
    input  logic                                i_ctx_valid,
    output logic                                o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]  i_ctx_data,
    output logic                                o_res_valid,
    input  logic                                i_res_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]  o_res_data,
    output logic                                o_res_last,
    output logic                                o_busy,
    output logic                                o_err,
    output logic [31:0]                         o_cycle_count,
    output logic                                o_qea_start,
    output logic                                o_qea_ctx_en,
    output logic                                o_qea_ctx_wea,
    output logic                                o_qea_state_ena,
    output logic                                o_qea_state_wea,
    output logic [MAX_QBIT_WIDTH-1:0]           o_qea_qbit_num,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  o_qea_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]  o_qea_ctx_data,
    output logic [STATE_ADDR_WIDTH-1:0]         o_qea_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]  o_qea_state_dina,
    input  logic                                i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]  i_qea_state_dout
);

    localparam int RW    = PE_NUM * STATE_DATA_WIDTH;
    localparam int HALF  = STATE_DATA_WIDTH / 2;
    localparam int RCW   = STATE_ADDR_WIDTH + 1;
    localparam int KCW   = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 2);
    localparam logic [HALF-1:0] ONE_FX = HALF'(1) << NUM_FRAC_BIT;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CTX, S_INIT, S_START, S_WAIT, S_READ_WAIT, S_READ_HOLD
    } state_t;

    state_t                               state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
    logic [KCW-1:0]                       ins_q, ins_d;
    logic [KCW-1:0]                       k_q, k_d;
    logic [RCW-1:0]                       row_q, row_d;
    logic [LAT_W-1:0]                     lat_q, lat_d;
    logic                                 ctx_ready_q, ctx_ready_d;
    logic                                 ctx_wr_q, ctx_wr_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q, ctx_addr_d;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q, ctx_data_d;
    logic                                 st_ena_q, st_ena_d;
    logic                                 st_wea_q, st_wea_d;
    logic [STATE_ADDR_WIDTH-1:0]          st_addra_q, st_addra_d;
    logic [RW-1:0]                        st_dina_q, st_dina_d;
    logic                                 start_q, start_d;
    logic [31:0]                          cycle_count_q, cycle_count_d;
    logic                                 res_valid_q, res_valid_d;
    logic                                 res_last_q, res_last_d;
    logic [RW-1:0]                        res_data_q, res_data_d;
    logic                                 busy_q, busy_d;
    logic                                 err_q, err_d;

    logic [RCW-1:0] rows_last;
    logic [RCW-1:0] row_inc;
    logic           run_bad;

    assign rows_last = (RCW'(1) << (qbit_q - MAX_QBIT_WIDTH'(2))) - RCW'(1);
    assign row_inc   = row_q + RCW'(1);
    assign run_bad   = (i_qbit_num < MAX_QBIT_WIDTH'(2))
                    || (32'(i_qbit_num) > 32'(STATE_ADDR_WIDTH + 2))
                    || (i_ins_num > {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}});

    // Next-state and next-output logic for the whole run sequence.
    always_comb begin
        // NOTE: every _d starts from its held value (or 0 for pulses) so no path leaves a latch.
        state_d       = state_q;
        qbit_d        = qbit_q;
        ins_d         = ins_q;
        k_d           = k_q;
        row_d         = row_q;
        lat_d         = lat_q;
        ctx_ready_d   = ctx_ready_q;
        ctx_wr_d      = 1'b0;
        ctx_addr_d    = ctx_addr_q;
        ctx_data_d    = ctx_data_q;
        st_ena_d      = 1'b0;
        st_wea_d      = 1'b0;
        st_addra_d    = st_addra_q;
        st_dina_d     = st_dina_q;
        start_d       = 1'b0;
        cycle_count_d = cycle_count_q;
        res_valid_d   = res_valid_q;
        res_last_d    = res_last_q;
        res_data_d    = res_data_q;
        err_d         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    if (run_bad) begin
                        err_d = 1'b1;
                    end else begin
                        qbit_d        = i_qbit_num;
                        ins_d         = i_ins_num;
                        cycle_count_d = '0;
                        k_d           = '0;
                        row_d         = '0;
                        if (i_ins_num == '0) begin
                            state_d = S_INIT;
                        end else begin
                            state_d     = S_LOAD_CTX;
                            ctx_ready_d = 1'b1;
                        end
                    end
                end
            end
            S_LOAD_CTX: begin
                if (i_ctx_valid && ctx_ready_q) begin
                    ctx_wr_d   = 1'b1;
                    ctx_addr_d = k_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    ctx_data_d = i_ctx_data;
                    k_d        = k_q + KCW'(1);
                    if (k_q == ins_q - KCW'(1)) begin
                        ctx_ready_d = 1'b0;
                        state_d     = S_INIT;
                    end
                end
            end
            S_INIT: begin
                st_ena_d   = 1'b1;
                st_wea_d   = 1'b1;
                st_addra_d = row_q[STATE_ADDR_WIDTH-1:0];
                st_dina_d  = '0;
                if (row_q == '0) begin
                    st_dina_d[RW-1 -: STATE_DATA_WIDTH] = {ONE_FX, HALF'(0)};
                end
                if (row_q == rows_last) begin
                    row_d   = '0;
                    state_d = S_START;
                end else begin
                    row_d = row_inc;
                end
            end
            S_START: begin
                start_d       = 1'b1;
                cycle_count_d = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                // A complete coinciding with the visible start pulse is ignored.
                if (i_qea_complete && !start_q) begin
                    st_ena_d   = 1'b1;
                    st_addra_d = '0;
                    row_d      = '0;
                    lat_d      = '0;
                    state_d    = S_READ_WAIT;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
            end
            S_READ_WAIT: begin
                if (lat_q == LAT_W'(READ_LATENCY)) begin
                    res_data_d  = i_qea_state_dout;
                    res_valid_d = 1'b1;
                    res_last_d  = (row_q == rows_last);
                    state_d     = S_READ_HOLD;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_READ_HOLD: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    res_last_d  = 1'b0;
                    if (res_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        row_d      = row_inc;
                        st_ena_d   = 1'b1;
                        st_addra_d = row_inc[STATE_ADDR_WIDTH-1:0];
                        lat_d      = '0;
                        state_d    = S_READ_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over every other event; the measured count is kept.
        if (i_abort && (state_q != S_IDLE)) begin
            state_d       = S_IDLE;
            ctx_ready_d   = 1'b0;
            ctx_wr_d      = 1'b0;
            st_ena_d      = 1'b0;
            st_wea_d      = 1'b0;
            start_d       = 1'b0;
            res_valid_d   = 1'b0;
            res_last_d    = 1'b0;
            cycle_count_d = cycle_count_q;
            err_d         = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            qbit_q        <= '0;
            ins_q         <= '0;
            k_q           <= '0;
            row_q         <= '0;
            lat_q         <= '0;
            ctx_ready_q   <= 1'b0;
            ctx_wr_q      <= 1'b0;
            ctx_addr_q    <= '0;
            ctx_data_q    <= '0;
            st_ena_q      <= 1'b0;
            st_wea_q      <= 1'b0;
            st_addra_q    <= '0;
            st_dina_q     <= '0;
            start_q       <= 1'b0;
            cycle_count_q <= '0;
            res_valid_q   <= 1'b0;
            res_last_q    <= 1'b0;
            res_data_q    <= '0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q       <= state_d;
            qbit_q        <= qbit_d;
            ins_q         <= ins_d;
            k_q           <= k_d;
            row_q         <= row_d;
            lat_q         <= lat_d;
            ctx_ready_q   <= ctx_ready_d;
            ctx_wr_q      <= ctx_wr_d;
            ctx_addr_q    <= ctx_addr_d;
            ctx_data_q    <= ctx_data_d;
            st_ena_q      <= st_ena_d;
            st_wea_q      <= st_wea_d;
            st_addra_q    <= st_addra_d;
            st_dina_q     <= st_dina_d;
            start_q       <= start_d;
            cycle_count_q <= cycle_count_d;
            res_valid_q   <= res_valid_d;
            res_last_q    <= res_last_d;
            res_data_q    <= res_data_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign o_ctx_ready       = ctx_ready_q;
    assign o_res_valid       = res_valid_q;
    assign o_res_data        = res_data_q;
    assign o_res_last        = res_last_q;
    assign o_busy            = busy_q;
    assign o_err             = err_q;
    assign o_cycle_count     = cycle_count_q;
    assign o_qea_start       = start_q;
    assign o_qea_ctx_en      = ctx_wr_q;
    assign o_qea_ctx_wea     = ctx_wr_q;
    assign o_qea_state_ena   = st_ena_q;
    assign o_qea_state_wea   = st_wea_q;
    assign o_qea_qbit_num    = qbit_q;
    assign o_qea_ctx_addr    = ctx_addr_q;
    assign o_qea_ctx_data    = ctx_data_q;
    assign o_qea_state_addra = st_addra_q;
    assign o_qea_state_dina  = st_dina_q;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Bench for qea_host_sequencer: a transaction-level model of QEA (state RAM,
// start/complete timing) and a per-cycle compare process.
module tb_qea_host_sequencer;

    localparam int RW = 256;
    localparam logic [RW-1:0] EXP_ROW0 = {64'h40000000_00000000, 192'h0};

    logic            clk, rst_n;
    logic            i_run, i_abort;
    logic [5:0]      i_qbit_num;
    logic [16:0]     i_ins_num;
    logic            i_ctx_valid, o_ctx_ready;
    logic [63:0]     i_ctx_data;
    logic            o_res_valid, i_res_ready, o_res_last;
    logic [RW-1:0]   o_res_data;
    logic            o_busy, o_err;
    logic [31:0]     o_cycle_count;
    logic            o_qea_start, o_qea_ctx_en, o_qea_ctx_wea, o_qea_state_ena, o_qea_state_wea;
    logic [5:0]      o_qea_qbit_num;
    logic [15:0]     o_qea_ctx_addr;
    logic [63:0]     o_qea_ctx_data;
    logic [15:0]     o_qea_state_addra;
    logic [RW-1:0]   o_qea_state_dina;
    logic            i_qea_complete;
    logic [RW-1:0]   i_qea_state_dout;

    qea_host_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_abort(i_abort),
        .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_res_last(o_res_last), .o_busy(o_busy), .o_err(o_err), .o_cycle_count(o_cycle_count),
        .o_qea_start(o_qea_start), .o_qea_ctx_en(o_qea_ctx_en), .o_qea_ctx_wea(o_qea_ctx_wea),
        .o_qea_state_ena(o_qea_state_ena), .o_qea_state_wea(o_qea_state_wea),
        .o_qea_qbit_num(o_qea_qbit_num), .o_qea_ctx_addr(o_qea_ctx_addr),
        .o_qea_ctx_data(o_qea_ctx_data), .o_qea_state_addra(o_qea_state_addra),
        .o_qea_state_dina(o_qea_state_dina), .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Shared model state.
    logic [RW-1:0] mem      [64];
    logic [RW-1:0] exp_rows [64];
    int cur_rows  = 1;
    int qea_delay = 1;
    int start_cnt = 0;
    int init_wr   = 0;
    int res_idx   = 0;
    int ctx_k     = 0;
    bit pend_ctx  = 0;
    logic [63:0] pend_word;
    int pend_idx  = 0;
    bit pend_rd   = 0;
    int pend_rd_addr = 0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Compare process: half a cycle after each rising edge, check outputs and
    // predict the handshakes the next rising edge will take. Also the state RAM.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            check("ctx_en", o_qea_ctx_en, pend_ctx);
            check("ctx_wea", o_qea_ctx_wea, pend_ctx);
            if (pend_ctx) begin
                check("ctx_addr", o_qea_ctx_addr, pend_idx);
                check("ctx_data", o_qea_ctx_data, pend_word);
            end
            if (o_res_valid && res_idx < 64) begin
                check("res_data", o_res_data, exp_rows[res_idx]);
                check("res_last", o_res_last, res_idx == cur_rows - 1);
            end
            // State RAM model, one cycle read latency.
            if (pend_rd) i_qea_state_dout = mem[pend_rd_addr];
            pend_rd = 0;
            if (i_qea_complete)
                for (int i = 0; i < cur_rows; i++) mem[i] = exp_rows[i];
            if (o_qea_state_ena) begin
                if (o_qea_state_wea) begin
                    check("init_addr", o_qea_state_addra, init_wr);
                    check("init_dina", o_qea_state_dina, (init_wr == 0) ? EXP_ROW0 : '0);
                    mem[o_qea_state_addra[5:0]] = o_qea_state_dina;
                    init_wr++;
                end else begin
                    pend_rd = 1;
                    pend_rd_addr = int'(o_qea_state_addra[5:0]);
                end
            end
            // Upcoming-edge predictions.
            if (i_run && !o_busy) begin
                ctx_k = 0; res_idx = 0; init_wr = 0;
            end
            pend_ctx = i_ctx_valid && o_ctx_ready;
            if (pend_ctx) begin
                pend_word = i_ctx_data; pend_idx = ctx_k; ctx_k++;
            end
            if (o_res_valid && i_res_ready) res_idx++;
        end else begin
            pend_ctx = 0;
            pend_rd  = 0;
        end
    end

    // QEA behaviour: on start, invent result rows, assert complete qea_delay
    // cycles later unless the run went idle first.
    initial begin
        i_qea_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (o_qea_start) begin
                int d;
                bit alive;
                start_cnt++;
                for (int i = 0; i < cur_rows; i++)
                    exp_rows[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                                   $urandom(), $urandom(), $urandom(), $urandom()};
                d = 0; alive = 1;
                while (d < qea_delay && alive) begin
                    @(negedge clk);
                    d++;
                    if (!o_busy) alive = 0;
                end
                if (alive) begin
                    i_qea_complete = 1'b1;
                    @(negedge clk);
                    i_qea_complete = 1'b0;
                end
            end
        end
    end

    int last_qb = 0;

    task automatic run(input int qb, input int ins, input int vmode, input int rmode, input int delay);
        logic [63:0] words[$];
        int w, cyc, hold, s0;
        bit tog;
        cur_rows  = 1 << (qb - 2);
        qea_delay = delay;
        s0 = start_cnt;
        for (int i = 0; i < ins; i++) words.push_back({$urandom(), $urandom()});
        @(negedge clk);
        i_qbit_num = 6'(qb); i_ins_num = 17'(ins); i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        last_qb = qb;
        check("busy_on_accept", o_busy, 1);
        check("count_cleared", o_cycle_count, 0);
        check("qbit_latched", o_qea_qbit_num, qb);
        w = 0; cyc = 0; tog = 1;
        while (w < ins && cyc < 5000) begin
            case (vmode)
                0:       i_ctx_valid = 1'b1;
                1:       i_ctx_valid = tog;
                default: i_ctx_valid = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            i_ctx_data = words[w];
            if (i_ctx_valid && o_ctx_ready) w++;
            @(negedge clk);
            cyc++;
        end
        i_ctx_valid = 1'b0;
        check("ctx_stream_done", w, ins);
        cyc = 0; hold = 0;
        while (o_busy && cyc < 5000) begin
            case (rmode)
                0: i_res_ready = 1'b1;
                1: begin
                    i_res_ready = !(o_res_valid && hold < 5);
                    if (o_res_valid) hold++;
                end
                default: i_res_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            cyc++;
        end
        i_res_ready = 1'b0;
        check("run_finished", o_busy, 0);
        check("rows_returned", res_idx, cur_rows);
        check("init_rows", init_wr, cur_rows);
        check("one_start", start_cnt - s0, 1);
        check("cycle_count", o_cycle_count, delay);
    endtask

    task automatic reject(input int qb, input int ins);
        @(negedge clk);
        i_qbit_num = 6'(qb); i_ins_num = 17'(ins); i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        check("rej_err_pulse", o_err, 1);
        check("rej_busy", o_busy, 0);
        check("rej_ena", o_qea_state_ena, 0);
        @(negedge clk);
        check("rej_err_drop", o_err, 0);
        check("rej_busy2", o_busy, 0);
        check("rej_ready", o_ctx_ready, 0);
        check("rej_qbit_kept", o_qea_qbit_num, last_qb);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b1;
        i_run = 0; i_abort = 0; i_qbit_num = 0; i_ins_num = 0;
        i_ctx_valid = 0; i_ctx_data = 0; i_res_ready = 0;
        i_qea_state_dout = '0;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; exp_rows[i] = '0; end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_ctx_ready, 0);
        check("rst_valid", o_res_valid, 0);
        check("rst_count", o_cycle_count, 0);
        check("rst_qbit", o_qea_qbit_num, 0);
        check("rst_start", o_qea_start, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal 3-qubit run with literal expectations.
        run(3, 41, 0, 0, 100);
        check("nominal_count_100", o_cycle_count, 32'd100);
        check("nominal_rows_2", res_idx, 2);

        run(3, 6, 1, 0, 30);    // context backpressure
        run(4, 5, 0, 1, 17);    // result backpressure

        reject(1, 5);
        reject(3, 65537);
        reject(19, 1);

        run(2, 0, 0, 0, 7);     // no context, single row
        check("edge_rows_1", res_idx, 1);

        // Abort during WAIT.
        cur_rows = 2; qea_delay = 1000;
        @(negedge clk);
        i_qbit_num = 6'd3; i_ins_num = 17'd0; i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        cyc = 0;
        while (!o_qea_start && cyc < 100) begin @(negedge clk); cyc++; end
        check("abort_start_seen", o_qea_start, 1);
        repeat (10) @(negedge clk);
        check("abort_count_10", o_cycle_count, 10);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_idle", o_busy, 0);
        check("abort_ena", o_qea_state_ena, 0);
        check("abort_count_kept", o_cycle_count, 10);
        repeat (3) @(negedge clk);
        check("abort_count_frozen", o_cycle_count, 10);
        run(3, 3, 0, 0, 12);

        for (int n = 0; n < 6; n++)
            run($urandom_range(2, 5), $urandom_range(0, 20), 2, 2, $urandom_range(1, 40));

        // Reset while a result row is being held.
        cur_rows = 4; qea_delay = 20;
        @(negedge clk);
        i_qbit_num = 6'd4; i_ins_num = 17'd0; i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0; i_res_ready = 1'b0;
        cyc = 0;
        while (!o_res_valid && cyc < 200) begin @(negedge clk); cyc++; end
        check("read_reached", o_res_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_valid", o_res_valid, 0);
        check("mid_rst_data", o_res_data, 0);
        check("mid_rst_last", o_res_last, 0);
        check("mid_rst_count", o_cycle_count, 0);
        check("mid_rst_qbit", o_qea_qbit_num, 0);
        check("mid_rst_ena", o_qea_state_ena, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
